// File: rtl/mips_pkg.sv
// Shared MIPS core types: ALU control codes, decoder ALU classes, funct constants, ID/EX record.
// Latency: n/a (types only).
// Backpressure: n/a.
package mips_pkg;

  localparam int MIPS_XLEN = 32;
  localparam int MIPS_RIDX = 5;

  typedef enum logic [3:0] {
    ALU_SUB = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SLT = 4'd7,
    ALU_AND = 4'd10,
    ALU_NOR = 4'd12,
    ALU_XOR = 4'd13
  } alu_ctl_e;

  typedef enum logic [2:0] {
    CLS_ADD   = 3'd0,
    CLS_SUB   = 3'd1,
    CLS_FUNCT = 3'd2,
    CLS_AND   = 3'd3,
    CLS_OR    = 3'd4,
    CLS_XOR   = 3'd5,
    CLS_SLT   = 3'd6,
    CLS_RSVD  = 3'd7
  } alu_class_e;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef struct packed {
    logic                 valid;
    logic [MIPS_XLEN-1:0] rs_data;
    logic [MIPS_XLEN-1:0] rt_data;
    logic [MIPS_XLEN-1:0] imm;
    logic [MIPS_RIDX-1:0] rs;
    logic [MIPS_RIDX-1:0] rt;
    logic [MIPS_RIDX-1:0] wdest;
    alu_ctl_e             ctl;
    logic                 alusrc;
    logic                 regwrite;
    logic                 memread;
    logic                 memwrite;
    logic                 memtoreg;
    logic                 illegal;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '{
    valid:    1'b0,
    rs_data:  '0,
    rt_data:  '0,
    imm:      '0,
    rs:       '0,
    rt:       '0,
    wdest:    '0,
    ctl:      ALU_ADD,
    alusrc:   1'b0,
    regwrite: 1'b0,
    memread:  1'b0,
    memwrite: 1'b0,
    memtoreg: 1'b0,
    illegal:  1'b0
  };

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM result, then MEM/WB result, then latched register data.
// Latency: combinational.
// Backpressure: none.
module fwd_mux #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic            valid,
  input  logic [RIDX-1:0] idx,
  input  logic [XLEN-1:0] reg_data,
  input  logic            exm_regwrite,
  input  logic [RIDX-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_regwrite,
  input  logic [RIDX-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] data
);

  logic exm_hit;
  logic wb_hit;

  // r0 is hardwired to zero, so a write to it is never a forward source
  assign exm_hit = valid && exm_regwrite && (exm_rd != '0) && (exm_rd == idx);
  assign wb_hit  = valid && wb_regwrite  && (wb_rd  != '0) && (wb_rd  == idx);

  always_comb begin
    data = reg_data;
    if (exm_hit)     data = exm_result;
    else if (wb_hit) data = wb_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, operand forwarding and load-use detection.
// Latency: 1 cycle id_* to ex_*; forwarding and load_use_stall are combinational.
// Backpressure: stall holds the stage, flush (wins) loads a bubble.
module id_ex_stage import mips_pkg::*; #(
  parameter int XLEN = MIPS_XLEN,
  parameter int RIDX = MIPS_RIDX
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rs_data,
  input  logic [XLEN-1:0] id_rt_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RIDX-1:0] id_rs,
  input  logic [RIDX-1:0] id_rt,
  input  logic [RIDX-1:0] id_rd,
  input  logic [2:0]      id_alu_op,
  input  logic [5:0]      id_funct,
  input  logic            id_alusrc,
  input  logic            id_regdst,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_memtoreg,
  input  logic            exm_regwrite,
  input  logic [RIDX-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_regwrite,
  input  logic [RIDX-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctl,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_valid,
  output logic [RIDX-1:0] ex_wdest,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_memtoreg,
  output logic            ex_illegal,
  output logic            load_use_stall
);

  id_ex_t    r;
  id_ex_t    d_next;
  alu_ctl_e  dec_ctl;
  logic      dec_illegal;
  logic [XLEN-1:0] rs_fwd;
  logic [XLEN-1:0] rt_fwd;

  always_comb begin
    dec_ctl     = ALU_ADD;
    dec_illegal = 1'b0;
    case (alu_class_e'(id_alu_op))
      CLS_ADD: dec_ctl = ALU_ADD;
      CLS_SUB: dec_ctl = ALU_SUB;
      CLS_AND: dec_ctl = ALU_AND;
      CLS_OR:  dec_ctl = ALU_OR;
      CLS_XOR: dec_ctl = ALU_XOR;
      CLS_SLT: dec_ctl = ALU_SLT;
      CLS_FUNCT: begin
        case (id_funct)
          FN_ADD, FN_ADDU: dec_ctl = ALU_ADD;
          FN_SUB, FN_SUBU: dec_ctl = ALU_SUB;
          FN_AND:          dec_ctl = ALU_AND;
          FN_OR:           dec_ctl = ALU_OR;
          FN_XOR:          dec_ctl = ALU_XOR;
          FN_NOR:          dec_ctl = ALU_NOR;
          FN_SLT:          dec_ctl = ALU_SLT;
          default:         dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    d_next = ID_EX_BUBBLE;
    if (id_valid) begin
      d_next.valid    = 1'b1;
      d_next.rs_data  = id_rs_data;
      d_next.rt_data  = id_rt_data;
      d_next.imm      = id_imm;
      d_next.rs       = id_rs;
      d_next.rt       = id_rt;
      d_next.wdest    = id_regdst ? id_rd : id_rt;
      d_next.ctl      = dec_ctl;
      d_next.alusrc   = id_alusrc;
      d_next.regwrite = id_regwrite;
      d_next.memread  = id_memread;
      d_next.memwrite = id_memwrite;
      d_next.memtoreg = id_memtoreg;
      d_next.illegal  = dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r <= ID_EX_BUBBLE;
    else if (flush)  r <= ID_EX_BUBBLE;
    else if (!stall) r <= d_next;
  end

  fwd_mux #(.XLEN(XLEN), .RIDX(RIDX)) u_fwd_rs (
    .valid        (r.valid),
    .idx          (r.rs),
    .reg_data     (r.rs_data),
    .exm_regwrite (exm_regwrite),
    .exm_rd       (exm_rd),
    .exm_result   (exm_result),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .data         (rs_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .RIDX(RIDX)) u_fwd_rt (
    .valid        (r.valid),
    .idx          (r.rt),
    .reg_data     (r.rt_data),
    .exm_regwrite (exm_regwrite),
    .exm_rd       (exm_rd),
    .exm_result   (exm_result),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .data         (rt_fwd)
  );

  assign alu_a         = rs_fwd;
  assign alu_b         = r.alusrc ? r.imm : rt_fwd;
  assign alu_ctl       = r.ctl;
  assign ex_store_data = rt_fwd;
  assign ex_valid      = r.valid;
  assign ex_wdest      = r.wdest;
  assign ex_regwrite   = r.regwrite;
  assign ex_memread    = r.memread;
  assign ex_memwrite   = r.memwrite;
  assign ex_memtoreg   = r.memtoreg;
  assign ex_illegal    = r.illegal;

  // A load in EX cannot forward its data yet; the consumer in decode must wait one cycle
  assign load_use_stall = r.valid && r.memread && (r.wdest != '0) && id_valid &&
                          ((r.wdest == id_rs) || (r.wdest == id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver queues hand-computed expectations, monitor checks them.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam int XLEN = 32;
  localparam int RIDX = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, stall, flush, id_valid;
  logic [XLEN-1:0] id_rs_data, id_rt_data, id_imm;
  logic [RIDX-1:0] id_rs, id_rt, id_rd;
  logic [2:0]      id_alu_op;
  logic [5:0]      id_funct;
  logic            id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic            exm_regwrite, wb_regwrite;
  logic [RIDX-1:0] exm_rd, wb_rd;
  logic [XLEN-1:0] exm_result, wb_result;
  logic [XLEN-1:0] alu_a, alu_b, ex_store_data;
  logic [3:0]      alu_ctl;
  logic            ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal;
  logic [RIDX-1:0] ex_wdest;
  logic            load_use_stall;

  id_ex_stage #(.XLEN(XLEN), .RIDX(RIDX)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_wdest(ex_wdest), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_illegal(ex_illegal), .load_use_stall(load_use_stall)
  );

  localparam int S_A = 0, S_B = 1, S_CTL = 2, S_ST = 3, S_VLD = 4, S_WD = 5;
  localparam int S_RW = 6, S_MR = 7, S_MW = 8, S_MTR = 9, S_ILL = 10, S_LUS = 11;

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int s);
    case (s)
      S_A:     return alu_a;
      S_B:     return alu_b;
      S_CTL:   return {28'd0, alu_ctl};
      S_ST:    return ex_store_data;
      S_VLD:   return {31'd0, ex_valid};
      S_WD:    return {27'd0, ex_wdest};
      S_RW:    return {31'd0, ex_regwrite};
      S_MR:    return {31'd0, ex_memread};
      S_MW:    return {31'd0, ex_memwrite};
      S_MTR:   return {31'd0, ex_memtoreg};
      S_ILL:   return {31'd0, ex_illegal};
      default: return {31'd0, load_use_stall};
    endcase
  endfunction

  // d = 0: visible this cycle (combinational); d = 1: after the next edge (registered)
  task automatic push_exp(int d, string n, int s, logic [31:0] v);
    exp_t e;
    e.cyc  = cyc + d;
    e.name = n;
    e.sel  = s;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic scan();
    int i;
    logic [31:0] a;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc <= cyc) begin
        a = actual(q[i].sel);
        n_chk++;
        if (a === q[i].val) n_pass++;
        else $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)", q[i].name, a, q[i].val, cyc);
        q.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    scan();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_id();
    id_valid = 0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_alu_op = '0; id_funct = '0;
    id_alusrc = 0; id_regdst = 0; id_regwrite = 0;
    id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0;
    idle_id();
    exm_regwrite = 0; exm_rd = '0; exm_result = '0;
    wb_regwrite = 0; wb_rd = '0; wb_result = '0;
    tick(); tick();
    push_exp(0, "rst_ctl", S_CTL, 32'd2);
    push_exp(0, "rst_vld", S_VLD, 32'd0);
    push_exp(0, "rst_rw",  S_RW,  32'd0);
    tick();
    rst_n = 1;

    // R-type NOR
    id_valid = 1; id_alu_op = 3'd2; id_funct = 6'h27;
    id_rs_data = 32'hF0F0_0000; id_rt_data = 32'h0F0F_0000;
    id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_regdst = 1; id_regwrite = 1;
    push_exp(1, "nor_ctl", S_CTL, 32'd12);
    push_exp(1, "nor_a",   S_A,   32'hF0F0_0000);
    push_exp(1, "nor_b",   S_B,   32'h0F0F_0000);
    push_exp(1, "nor_wd",  S_WD,  32'd3);
    push_exp(1, "nor_vld", S_VLD, 32'd1);
    push_exp(1, "nor_ill", S_ILL, 32'd0);
    tick();

    // unsupported funct
    id_funct = 6'h08; id_regdst = 0;
    push_exp(1, "bad_ill", S_ILL, 32'd1);
    push_exp(1, "bad_ctl", S_CTL, 32'd2);
    push_exp(1, "bad_wd",  S_WD,  32'd2);
    tick();

    // SLT with immediate
    id_alu_op = 3'd6; id_alusrc = 1; id_imm = 32'hFFFF_FFFC;
    id_rs_data = 32'h8000_0000; id_rt_data = 32'h0000_1234;
    push_exp(1, "imm_b",   S_B,   32'hFFFF_FFFC);
    push_exp(1, "imm_ctl", S_CTL, 32'd7);
    push_exp(1, "imm_a",   S_A,   32'h8000_0000);
    push_exp(1, "imm_st",  S_ST,  32'h0000_1234);
    push_exp(1, "imm_ill", S_ILL, 32'd0);
    tick();

    // AND with rs = r5, then hold it under stall while forward sources move
    id_alu_op = 3'd3; id_alusrc = 0; id_rs = 5'd5; id_rs_data = 32'h55;
    id_rt = 5'd6; id_rt_data = 32'h66; id_rd = 5'd7; id_regdst = 1;
    push_exp(1, "and_ctl", S_CTL, 32'd10);
    push_exp(1, "and_wd",  S_WD,  32'd7);
    tick();
    stall = 1; id_alu_op = 3'd4; id_rd = 5'd9; id_rs_data = 32'h999;
    exm_regwrite = 1; exm_rd = 5'd5; exm_result = 32'h11;
    wb_regwrite = 1;  wb_rd = 5'd5;  wb_result = 32'h22;
    push_exp(0, "fwd_exm",     S_A,  32'h11);
    push_exp(0, "fwd_rt_none", S_ST, 32'h66);
    tick();
    exm_regwrite = 0;
    push_exp(0, "fwd_wb",    S_A,   32'h22);
    push_exp(0, "stall_ctl", S_CTL, 32'd10);
    tick();
    exm_regwrite = 1; exm_rd = '0; wb_rd = '0;
    push_exp(0, "fwd_rd0",    S_A,   32'h55);
    push_exp(0, "stall_wd",   S_WD,  32'd7);
    push_exp(0, "stall_vld",  S_VLD, 32'd1);
    push_exp(1, "stall3_ctl", S_CTL, 32'd10);
    tick();

    // stall and flush together
    flush = 1; exm_regwrite = 0; wb_regwrite = 0;
    push_exp(1, "flush_vld", S_VLD, 32'd0);
    push_exp(1, "flush_ctl", S_CTL, 32'd2);
    push_exp(1, "flush_a",   S_A,   32'd0);
    tick();
    flush = 0; stall = 0;
    idle_id();

    // lw r8, 4(r3) followed by a consumer of r8
    id_valid = 1; id_alu_op = 3'd0; id_memread = 1; id_regwrite = 1; id_memtoreg = 1;
    id_alusrc = 1; id_regdst = 0; id_rt = 5'd8; id_rs = 5'd3; id_rs_data = 32'h100; id_imm = 32'd4;
    push_exp(1, "lw_mr",  S_MR,  32'd1);
    push_exp(1, "lw_wd",  S_WD,  32'd8);
    push_exp(1, "lw_b",   S_B,   32'd4);
    push_exp(1, "lw_mtr", S_MTR, 32'd1);
    tick();
    id_memread = 0; id_memtoreg = 0; id_alusrc = 0; id_rs = 5'd8; id_rt = 5'd9;
    id_rd = 5'd10; id_regdst = 1; id_rs_data = 32'hDEAD;
    push_exp(0, "lus_hit", S_LUS, 32'd1);
    flush = 1;
    tick();
    flush = 0;
    push_exp(0, "lus_bubble", S_LUS, 32'd0);
    push_exp(0, "lu_bub_vld", S_VLD, 32'd0);
    tick();
    wb_regwrite = 1; wb_rd = 5'd8; wb_result = 32'hCAFE;
    push_exp(0, "lu_wb_fwd", S_A,   32'hCAFE);
    push_exp(0, "lu_vld",    S_VLD, 32'd1);
    push_exp(0, "lu_lus",    S_LUS, 32'd0);
    push_exp(0, "lu_mw",     S_MW,  32'd0);
    stall = 1;
    tick();

    // asynchronous reset while stalled
    rst_n = 0;
    push_exp(0, "rst_mid_vld", S_VLD, 32'd0);
    push_exp(0, "rst_mid_ctl", S_CTL, 32'd2);
    push_exp(0, "rst_mid_rw",  S_RW,  32'd0);
    push_exp(0, "rst_mid_wd",  S_WD,  32'd0);
    tick(); tick();
    rst_n = 1; stall = 0;
    idle_id();
    repeat (3) tick();

    foreach (q[i]) begin
      n_chk++;
      $display("FAIL %s: never sampled, want 0x%h", q[i].name, q[i].val);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
